// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and default constants for the run sequencer
//
// Purpose: state encoding for run_ctrl plus the default parameter values
//          used by run_ctrl and run_cycle_counter.
// Ports:   none (package)

package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        REQ  = 3'd2,
        RUN  = 3'd3,
        FIN  = 3'd4,
        TMO  = 3'd5
    } run_state_t;

    localparam int DEF_RST_CYC = 4;
    localparam int DEF_CW      = 16;
    localparam int DEF_TIMEOUT = 4096;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// rtl/run_cycle_counter.sv - saturating RUN-cycle counter with timeout match
//
// Purpose: counts RUN cycles. Synchronous clear has priority over enable.
//          The count saturates at all-ones and never wraps. next_hit flags
//          that the value the counter would load on an enabled cycle equals
//          TIMEOUT, so the FSM can leave RUN on the same edge the count
//          reaches TIMEOUT.
// Ports:
//   clk       in   1    system clock
//   reset     in   1    synchronous, active-high
//   clr       in   1    synchronous clear
//   en        in   1    count enable
//   count     out  CW   current count (registered)
//   next_hit  out  1    count+1 (saturated) equals TIMEOUT

module run_cycle_counter
    import run_ctrl_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          next_hit
);

    localparam logic [CW-1:0] MAX_VAL = '1;
    localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT);

    logic [CW-1:0] next_val;

    always_comb begin
        next_val = (count == MAX_VAL) ? count : count + 1'b1;
        next_hit = (next_val == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= next_val;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run sequencer driving the core's reset/req/done handshake
//
// Purpose: on start, holds the core in reset for RST_CYC cycles, pulses req
//          for one cycle, then counts RUN cycles until core_done or TIMEOUT.
//          Reports sticky finished / timed_out flags; abort cancels a run.
// Ports:
//   clk          in   1    system clock
//   reset        in   1    synchronous, active-high
//   start        in   1    launch a run (level, sampled per cycle)
//   abort        in   1    cancel the current run
//   core_done    in   1    core done flag
//   core_reset   out  1    reset to core
//   core_req     out  1    req to core
//   busy         out  1    run in progress
//   finished     out  1    sticky: last run ended by core_done
//   timed_out    out  1    sticky: last run hit TIMEOUT
//   cycle_count  out  CW   RUN cycles of current/last run

module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count
);

    localparam int RCW = cnt_width(RST_CYC);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

    run_state_t     state;
    logic [RCW-1:0] rst_cnt;

    logic can_start;
    logic abort_hit;
    logic cnt_clr;
    logic cnt_en;
    logic next_hit;

    always_comb begin
        can_start = start && (state == IDLE || state == FIN || state == TMO);
        abort_hit = abort && (state == RST || state == REQ || state == RUN);
        cnt_clr   = can_start || abort_hit;
        // Done wins over the timeout edge, so a done cycle must not count.
        cnt_en    = (state == RUN) && !core_done;
    end

    run_cycle_counter #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (cycle_count),
        .next_hit (next_hit)
    );

    always_ff @(posedge clk) begin
        if (reset || abort_hit) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b0;
            core_req   <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN, TMO: begin
                    if (start) begin
                        state      <= RST;
                        rst_cnt    <= '0;
                        core_reset <= 1'b1;
                        busy       <= 1'b1;
                        finished   <= 1'b0;
                        timed_out  <= 1'b0;
                    end
                end
                RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state      <= REQ;
                        core_reset <= 1'b0;
                        core_req   <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                REQ: begin
                    state    <= RUN;
                    core_req <= 1'b0;
                end
                RUN: begin
                    if (core_done) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        finished <= 1'b1;
                    end else if (next_hit) begin
                        state     <= TMO;
                        busy      <= 1'b0;
                        timed_out <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    core_reset <= 1'b0;
                    core_req   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - scoreboard bench for run_ctrl with a timeline reference model

module tb_run_ctrl;

    localparam int RST_CYC = 4;
    localparam int CW      = 16;
    localparam int TIMEOUT = 60;
    localparam int RUN_T   = RST_CYC + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          core_done = 1'b0;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    run_ctrl #(
        .RST_CYC (RST_CYC),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .core_done   (core_done),
        .core_reset  (core_reset),
        .core_req    (core_req),
        .busy        (busy),
        .finished    (finished),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    typedef struct packed {
        logic          cr;
        logic          rq;
        logic          bsy;
        logic          fin;
        logic          tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a run is a timeline measured from the start edge.
    // m_t = cycles since start was accepted; 1..RST_CYC core reset,
    // RST_CYC+1 req pulse, RUN_T onward the core is running.
    bit m_run;
    int m_t;
    bit m_fin;
    bit m_tmo;
    int m_cnt;

    task automatic model_clear();
        m_run = 0; m_t = 0; m_fin = 0; m_tmo = 0; m_cnt = 0;
    endtask

    task automatic step(input bit rs, input bit st, input bit ab, input bit dn);
        exp_t e;
        @(negedge clk);
        reset = rs; start = st; abort = ab; core_done = dn;
        if (rs) begin
            model_clear();
        end else if (m_run) begin
            if (ab) begin
                model_clear();
            end else if (m_t >= RUN_T) begin
                if (dn) begin
                    m_fin = 1; m_run = 0;
                end else begin
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    if (m_cnt == TIMEOUT) begin
                        m_tmo = 1; m_run = 0;
                    end
                end
            end else begin
                m_t++;
            end
        end else if (st) begin
            m_run = 1; m_t = 1; m_fin = 0; m_tmo = 0; m_cnt = 0;
        end
        e.cr  = m_run && (m_t <= RST_CYC);
        e.rq  = m_run && (m_t == RST_CYC + 1);
        e.bsy = m_run;
        e.fin = m_fin;
        e.tmo = m_tmo;
        e.cnt = CW'(m_cnt);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("core_reset",  32'(core_reset),  32'(e.cr));
                chk("core_req",    32'(core_req),    32'(e.rq));
                chk("busy",        32'(busy),        32'(e.bsy));
                chk("finished",    32'(finished),    32'(e.fin));
                chk("timed_out",   32'(timed_out),   32'(e.tmo));
                chk("cycle_count", 32'(cycle_count), 32'(e.cnt));
            end
        end
    end

    // Advance with idle inputs until the model is in RUN with count n.
    task automatic run_until(input int n);
        int guard = 0;
        while (!(m_run && m_t >= RUN_T && m_cnt == n) && guard < 500) begin
            step(0, 0, 0, 0);
            guard++;
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL run_until %0d: bound expired, model cnt %0d", n, m_cnt);
        end
    endtask

    initial begin
        model_clear();
        repeat (3) step(1, 0, 0, 0);

        // Completed run: done at RUN count 50, then hold in FIN.
        step(0, 1, 0, 0);
        run_until(50);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 0);

        // Timeout with done held low.
        step(0, 1, 0, 0);
        for (int i = 0; i < 200 && m_run; i++) step(0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0);

        // Stale done during RST/REQ must be ignored.
        step(0, 1, 0, 1);
        while (m_run && m_t < RUN_T) step(0, 0, 0, 1);
        run_until(3);
        step(0, 0, 0, 1);

        // Done on the timeout edge: done wins.
        step(0, 1, 0, 0);
        run_until(TIMEOUT - 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // start mid-run ignored, abort at count 10.
        step(0, 1, 0, 0);
        run_until(5);
        repeat (2) step(0, 1, 0, 0);
        run_until(10);
        step(0, 1, 1, 1);
        repeat (2) step(0, 0, 0, 0);

        // Abort during RST.
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);

        // Reset mid-run then clean relaunch.
        step(0, 1, 0, 0);
        run_until(20);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        run_until(5);
        step(0, 0, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 250) == 0, ($urandom % 6) == 0,
                 ($urandom % 70) == 0, ($urandom % 45) == 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
